// File: rtl/pe_sched_pkg.sv
// Shared types and constants for the PE row scheduler.
package pe_sched_pkg;

  localparam int DATA_WIDTH   = 16;
  localparam int MAX_KERNEL   = 7;
  localparam int W_WIDTH      = 10;
  localparam int C_WIDTH      = 8;
  localparam int DEF_PIPE_LAT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_FLTR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } sched_state_e;

  typedef struct packed {
    logic [2:0]         kernel_size;
    logic [W_WIDTH-1:0] ifmap_width;
    logic [C_WIDTH-1:0] channels;
  } cfg_t;

  function automatic logic cfg_legal(cfg_t c);
    return (c.kernel_size != 3'd0) &&
           (int'(c.kernel_size) <= MAX_KERNEL) &&
           (c.ifmap_width >= W_WIDTH'(c.kernel_size)) &&
           (c.channels != C_WIDTH'(0));
  endfunction

endpackage

// File: rtl/pe_row_scheduler_if.sv
// Feeder-side handshake bundle between the DMA FIFOs and the row scheduler.
// A word moves in every cycle where valid and ready are both high; valid may
// not depend on ready, and the scheduler never raises both readies at once.
interface pe_row_scheduler_if;
  logic fltr_valid;
  logic fltr_ready;
  logic ifmap_valid;
  logic ifmap_ready;

  modport master (output fltr_valid, ifmap_valid, input fltr_ready, ifmap_ready);
  modport slave  (input fltr_valid, ifmap_valid, output fltr_ready, ifmap_ready);
endinterface

// File: rtl/psum_valid_pipe.sv
// Valid/column delay line that times psum_capture against the PE MAC latency.
module psum_valid_pipe #(
  parameter int DEPTH = 4,
  parameter int COL_W = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [COL_W-1:0] in_col,
  output logic             out_valid,
  output logic [COL_W-1:0] out_col,
  output logic             drained
);

  logic [DEPTH-1:0] vld;
  logic [COL_W-1:0] col_sr [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) col_sr[i] <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      vld       <= {vld[DEPTH-2:0], in_valid};
      col_sr[0] <= in_valid ? in_col : '0;
      for (int i = 1; i < DEPTH; i++) col_sr[i] <= col_sr[i-1];
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_col   = vld[DEPTH-1] ? col_sr[DEPTH-1] : '0;
  // Only the output stage may still be occupied: it empties on this edge.
  assign drained   = ~|vld[DEPTH-2:0];

endmodule

// File: rtl/pe_row_scheduler.sv
// Sequences one PE row through K filter taps and W ifmap words per channel,
// timing psum captures for every valid output column.
module pe_row_scheduler
  import pe_sched_pkg::*;
#(
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     abort,
  input  logic [2:0]               cfg_kernel_size,
  input  logic [W_WIDTH-1:0]       cfg_ifmap_width,
  input  logic [C_WIDTH-1:0]       cfg_channels,
  pe_row_scheduler_if.slave        feed,
  output logic                     pe_ready,
  output logic                     pe_fltr_load,
  output logic                     pe_external,
  output logic                     pe_ipsum_clear,
  output logic [2:0]               kernel_size,
  output logic                     psum_capture,
  output logic [W_WIDTH-1:0]       psum_col,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err,
  output sched_state_e             dbg_state
);

  sched_state_e       state, state_d;
  cfg_t               cfg_in, cfg_q;
  logic [2:0]         tap;
  logic [W_WIDTH-1:0] col, km1, launch_col;
  logic [C_WIDTH-1:0] ch;
  logic               pe_ready_q, cfg_err_q;
  logic               fltr_hs, ifmap_hs, start_ok;
  logic               last_tap, last_col, last_ch, launch, pipe_drained;

  assign cfg_in   = '{kernel_size: cfg_kernel_size,
                      ifmap_width: cfg_ifmap_width,
                      channels:    cfg_channels};
  assign start_ok = start && cfg_legal(cfg_in);

  assign feed.fltr_ready  = (state == S_LOAD_FLTR);
  assign feed.ifmap_ready = (state == S_STREAM);
  assign fltr_hs  = feed.fltr_valid  && feed.fltr_ready;
  assign ifmap_hs = feed.ifmap_valid && feed.ifmap_ready;

  assign last_tap   = (tap == cfg_q.kernel_size - 3'd1);
  assign last_col   = (col == cfg_q.ifmap_width - W_WIDTH'(1));
  assign last_ch    = (ch == cfg_q.channels - C_WIDTH'(1));
  assign km1        = W_WIDTH'(cfg_q.kernel_size) - W_WIDTH'(1);
  // The first K-1 words of a channel only prime the PE shifter.
  assign launch     = ifmap_hs && (col >= km1) && !abort;
  assign launch_col = col - km1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:      if (start_ok) state_d = S_LOAD_FLTR;
      S_LOAD_FLTR: if (fltr_hs && last_tap) state_d = S_STREAM;
      S_STREAM:    if (ifmap_hs && last_col) state_d = last_ch ? S_DRAIN : S_LOAD_FLTR;
      S_DRAIN:     if (pipe_drained) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_q      <= '0;
      tap        <= '0;
      col        <= '0;
      ch         <= '0;
      pe_ready_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      pe_ready_q <= ifmap_hs && !abort;
      cfg_err_q  <= (state == S_IDLE) && start && !abort && !cfg_legal(cfg_in);
      if (abort) begin
        tap <= '0;
        col <= '0;
        ch  <= '0;
      end else begin
        case (state)
          S_IDLE: if (start_ok) begin
            cfg_q <= cfg_in;
            tap   <= '0;
            ch    <= '0;
          end
          S_LOAD_FLTR: if (fltr_hs) begin
            if (last_tap) begin
              tap <= '0;
              col <= '0;
            end else begin
              tap <= tap + 3'd1;
            end
          end
          S_STREAM: if (ifmap_hs) begin
            col <= col + W_WIDTH'(1);
            if (last_col && !last_ch) ch <= ch + C_WIDTH'(1);
          end
          // Return ch to 0 so IDLE presents the memory-fed PE configuration.
          S_DONE: ch <= '0;
          default: ;
        endcase
      end
    end
  end

  psum_valid_pipe #(
    .DEPTH (PIPE_LAT + 1),
    .COL_W (W_WIDTH)
  ) u_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (abort),
    .in_valid  (launch),
    .in_col    (launch_col),
    .out_valid (psum_capture),
    .out_col   (psum_col),
    .drained   (pipe_drained)
  );

  assign pe_ready       = pe_ready_q;
  assign pe_fltr_load   = fltr_hs;
  assign pe_external    = (ch == C_WIDTH'(0));
  assign pe_ipsum_clear = busy && (ch == C_WIDTH'(0));
  assign kernel_size    = cfg_q.kernel_size;
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);
  assign cfg_err        = cfg_err_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_pe_row_scheduler.sv
// Self-checking bench: cycle-level behavioural model of the pass schedule plus
// hand-computed expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_pe_row_scheduler;
  import pe_sched_pkg::*;

  localparam int PL = DEF_PIPE_LAT;
  localparam int P_IDLE = 0, P_FLTR = 1, P_STREAM = 2, P_DRAIN = 3, P_DONE = 4;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0, start = 1'b0, abort = 1'b0;
  logic [2:0]         cfg_k = '0;
  logic [W_WIDTH-1:0] cfg_w = '0;
  logic [C_WIDTH-1:0] cfg_c = '0;
  logic pe_ready, pe_fltr_load, pe_external, pe_ipsum_clear;
  logic psum_capture, busy, done, cfg_err;
  logic [2:0]         kernel_size;
  logic [W_WIDTH-1:0] psum_col;
  sched_state_e       dbg_state;

  pe_row_scheduler_if feed();

  pe_row_scheduler #(.PIPE_LAT(PL)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_kernel_size(cfg_k), .cfg_ifmap_width(cfg_w), .cfg_channels(cfg_c),
    .feed(feed),
    .pe_ready(pe_ready), .pe_fltr_load(pe_fltr_load), .pe_external(pe_external),
    .pe_ipsum_clear(pe_ipsum_clear), .kernel_size(kernel_size),
    .psum_capture(psum_capture), .psum_col(psum_col), .busy(busy), .done(done),
    .cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase, m_k, m_w, m_c, m_taps, m_cols, m_ch, m_done_due;
  logic [2:0] m_kq;
  logic m_rdy_pend, m_err_pend;
  int cap_due_q[$];
  logic [W_WIDTH-1:0] exp_q[$];

  // observation logs for directed expectations
  int done_cnt, cap_cnt, err_cnt, act_cnt, ihs_cnt, fl_cnt, rdy_cnt, nclr_cnt, ext0_cnt;
  int first_cap_cyc, d_snap;
  int ihs_cyc_q[$];
  logic [W_WIDTH-1:0] cap_log[$];

  task automatic model_reset();
    m_phase = P_IDLE; m_k = 0; m_w = 0; m_c = 0; m_taps = 0; m_cols = 0; m_ch = 0;
    m_done_due = -1; m_kq = '0; m_rdy_pend = 1'b0; m_err_pend = 1'b0;
    cap_due_q.delete(); exp_q.delete();
  endtask

  task automatic clear_logs();
    done_cnt = 0; cap_cnt = 0; err_cnt = 0; act_cnt = 0; ihs_cnt = 0; fl_cnt = 0;
    rdy_cnt = 0; nclr_cnt = 0; ext0_cnt = 0; first_cap_cyc = -1;
    ihs_cyc_q.delete(); cap_log.delete();
  endtask

  logic e_fr, e_ir, fhs, ihs, e_cap, legal;

  always @(negedge clk) begin
    if (!rstn) begin
      model_reset();
    end else begin
      e_fr  = (m_phase == P_FLTR);
      e_ir  = (m_phase == P_STREAM);
      fhs   = feed.fltr_valid && e_fr;
      ihs   = feed.ifmap_valid && e_ir;
      e_cap = (cap_due_q.size() > 0) && (cap_due_q[0] == cyc);

      chk("fltr_ready", feed.fltr_ready, e_fr);
      chk("ifmap_ready", feed.ifmap_ready, e_ir);
      chk("pe_fltr_load", pe_fltr_load, fhs);
      chk("pe_ready", pe_ready, m_rdy_pend);
      chk("busy", busy, m_phase != P_IDLE);
      chk("done", done, m_phase == P_DONE);
      chk("pe_external", pe_external, m_ch == 0);
      chk("pe_ipsum_clear", pe_ipsum_clear, (m_phase != P_IDLE) && (m_ch == 0));
      chk("kernel_size", kernel_size, m_kq);
      chk("cfg_err", cfg_err, m_err_pend);
      chk("psum_capture", psum_capture, e_cap);
      if (e_cap) begin
        chk("psum_col", psum_col, exp_q[0]);
        void'(cap_due_q.pop_front());
        void'(exp_q.pop_front());
      end

      if (psum_capture) begin
        cap_cnt++;
        cap_log.push_back(psum_col);
        if (first_cap_cyc < 0) first_cap_cyc = cyc;
      end
      if (done) done_cnt++;
      if (cfg_err) err_cnt++;
      if (busy || feed.fltr_ready || feed.ifmap_ready) act_cnt++;
      if (feed.ifmap_valid && feed.ifmap_ready) begin
        ihs_cnt++;
        ihs_cyc_q.push_back(cyc);
      end
      if (pe_fltr_load) fl_cnt++;
      if (pe_ready) rdy_cnt++;
      if (busy && !pe_ipsum_clear) nclr_cnt++;
      if (!pe_external) ext0_cnt++;

      // advance model across the coming clock edge
      legal = (int'(cfg_k) >= 1) && (int'(cfg_k) <= MAX_KERNEL) &&
              (int'(cfg_w) >= int'(cfg_k)) && (int'(cfg_c) >= 1);
      m_rdy_pend = ihs && !abort;
      m_err_pend = (m_phase == P_IDLE) && start && !abort && !legal;
      if (abort) begin
        m_phase = P_IDLE; m_ch = 0;
        cap_due_q.delete(); exp_q.delete();
      end else begin
        case (m_phase)
          P_IDLE: if (start && legal) begin
            m_k = int'(cfg_k); m_w = int'(cfg_w); m_c = int'(cfg_c); m_kq = cfg_k;
            m_ch = 0; m_taps = 0; m_phase = P_FLTR;
          end
          P_FLTR: if (fhs) begin
            m_taps++;
            if (m_taps == m_k) begin m_phase = P_STREAM; m_cols = 0; end
          end
          P_STREAM: if (ihs) begin
            if (m_cols >= m_k - 1) begin
              cap_due_q.push_back(cyc + PL + 1);
              exp_q.push_back(W_WIDTH'(m_cols - (m_k - 1)));
            end
            m_cols++;
            if (m_cols == m_w) begin
              if (m_ch < m_c - 1) begin m_ch++; m_taps = 0; m_phase = P_FLTR; end
              else begin m_phase = P_DRAIN; m_done_due = cyc + PL + 2; end
            end
          end
          P_DRAIN: if (cyc + 1 == m_done_due) m_phase = P_DONE;
          default: begin m_phase = P_IDLE; m_ch = 0; end
        endcase
      end
    end
  end

  // ---------------- drivers ----------------
  int feed_mode = 3;  // 0 all valid, 1 random, 2 ifmap toggles, 3 none, 4 ifmap only

  always @(posedge clk) begin
    #1;
    case (feed_mode)
      0:       begin feed.fltr_valid = 1'b1; feed.ifmap_valid = 1'b1; end
      1:       begin feed.fltr_valid = ($urandom_range(0, 3) != 0);
                     feed.ifmap_valid = ($urandom_range(0, 3) != 0); end
      2:       begin feed.fltr_valid = 1'b1; feed.ifmap_valid = cyc[0]; end
      4:       begin feed.fltr_valid = 1'b0; feed.ifmap_valid = 1'b1; end
      default: begin feed.fltr_valid = 1'b0; feed.ifmap_valid = 1'b0; end
    endcase
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int k, input int w, input int c);
    tick();
    d_snap = done_cnt;
    cfg_k = 3'(k); cfg_w = W_WIDTH'(w); cfg_c = C_WIDTH'(c);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == d_snap && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("done_timeout", done_cnt != d_snap, 1);
    repeat (2) tick();
  endtask

  // ---------------- directed + random scenarios ----------------
  initial begin
    feed.fltr_valid = 1'b0; feed.ifmap_valid = 1'b0;
    clear_logs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_pe_external", pe_external, 1);
    chk("rst_ipsum_clear", pe_ipsum_clear, 0);
    chk("rst_fltr_ready", feed.fltr_ready, 0);
    chk("rst_ifmap_ready", feed.ifmap_ready, 0);
    chk("rst_kernel_size", kernel_size, 0);
    chk("rst_psum_capture", psum_capture, 0);
    chk("rst_done", done, 0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rstn = 1'b1;
    tick();

    // K=3 W=8 C=1, feeders always valid
    clear_logs(); feed_mode = 0;
    do_start(3, 8, 1); wait_done(500);
    chk("t1_cap_cnt", cap_cnt, 6);
    for (int i = 0; i < 6; i++)
      chk("t1_cap_col", (i < cap_log.size()) ? 32'(cap_log[i]) : 32'hffff, i);
    chk("t1_first_cap_lat", (ihs_cyc_q.size() >= 3) ? first_cap_cyc - ihs_cyc_q[2] : -1, 4);
    chk("t1_fltr_loads", fl_cnt, 3);
    chk("t1_pe_ready_cnt", rdy_cnt, 8);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_nclr_cnt", nclr_cnt, 0);

    // K=3 W=5 C=2: second channel accumulates neighbour psum
    clear_logs();
    do_start(3, 5, 2); wait_done(500);
    chk("t2_cap_cnt", cap_cnt, 6);
    for (int i = 0; i < 6; i++)
      chk("t2_cap_col", (i < cap_log.size()) ? 32'(cap_log[i]) : 32'hffff, i % 3);
    chk("t2_ch1_nclr_cycles", nclr_cnt, 13);
    chk("t2_ch1_ext0_cycles", ext0_cnt, 13);
    chk("t2_done_cnt", done_cnt, 1);

    // K=2 W=6 with ifmap_valid toggling
    clear_logs(); feed_mode = 2;
    do_start(2, 6, 1); wait_done(500);
    chk("t3_cap_cnt", cap_cnt, 5);
    for (int i = 0; i < 5; i++)
      chk("t3_cap_col", (i < cap_log.size()) ? 32'(cap_log[i]) : 32'hffff, i);
    chk("t3_pe_ready_cnt", rdy_cnt, 6);

    // illegal configurations
    clear_logs(); feed_mode = 0;
    do_start(0, 8, 1); repeat (3) tick();
    do_start(4, 3, 1); repeat (3) tick();
    do_start(2, 8, 0); repeat (3) tick();
    chk("t4_err_cnt", err_cnt, 3);
    chk("t4_activity", act_cnt, 0);

    // abort mid-stream with captures in flight
    clear_logs();
    do_start(3, 8, 1);
    begin
      int n = 0;
      while (ihs_cnt < 5 && n < 200) begin @(posedge clk); n++; end
      chk("t5_reach_stream", ihs_cnt >= 5, 1);
    end
    #1; abort = 1'b1;
    tick(); abort = 1'b0;
    chk("t5_idle_after_abort", busy, 0);
    repeat (10) tick();
    chk("t5_cap_cnt", cap_cnt, 0);
    chk("t5_done_cnt", done_cnt, 0);
    clear_logs();
    do_start(3, 8, 1); wait_done(500);
    chk("t5_rerun_cap_cnt", cap_cnt, 6);
    chk("t5_rerun_done_cnt", done_cnt, 1);

    // asynchronous reset while waiting for filter words
    clear_logs(); feed_mode = 4;
    do_start(5, 8, 1); repeat (3) tick();
    chk("t6_busy_before", busy, 1);
    #1; rstn = 1'b0; #1;
    chk("t6_busy", busy, 0);
    chk("t6_pe_external", pe_external, 1);
    chk("t6_fltr_ready", feed.fltr_ready, 0);
    chk("t6_kernel_size", kernel_size, 0);
    chk("t6_ipsum_clear", pe_ipsum_clear, 0);
    chk("t6_state", 32'(dbg_state), 32'(S_IDLE));
    @(posedge clk); #1; rstn = 1'b1;
    tick();

    // randomized passes, some aborted, with stray starts while busy
    for (int p = 0; p < 20; p++) begin
      int k, w, c;
      k = $urandom_range(1, MAX_KERNEL);
      w = $urandom_range(k, k + 10);
      c = $urandom_range(1, 3);
      feed_mode = 1;
      do_start(k, w, c);
      tick();
      cfg_k = 3'($urandom_range(0, 7)); start = 1'b1;
      tick(); start = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 30)) tick();
        abort = 1'b1; tick(); abort = 1'b0; repeat (6) tick();
      end else begin
        wait_done(3000);
      end
    end
    feed_mode = 3;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
